// File: rtl/fsm_board_pkg.sv
// fsm_board_pkg
// Shared widths and types for the board-level step controller.
//   STATE_W       width of the observed FSM state
//   STEP_CNT_W    width of the step counter
//   db_state_t    push-button debounce FSM states
//   trace_entry_t one recorded {state, out} sample
package fsm_board_pkg;

    localparam int STATE_W    = 3;
    localparam int STEP_CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE_LOW,
        WAIT_HIGH,
        IDLE_HIGH,
        WAIT_LOW
    } db_state_t;

    typedef struct packed {
        logic [STATE_W-1:0] state;
        logic               out;
    } trace_entry_t;

endpackage

// File: rtl/fsm_step_ctrl_if.sv
// fsm_step_ctrl_if
// Bundle between the step controller and the FSM / LED readback side.
//   step         step strobe to the FSM
//   step_count   steps issued, mod 256
//   state_obs    FSM current state
//   out_obs      FSM registered output
//   rd_idx       trace read index, 0 = most recent
//   trace_state  recorded state at rd_idx
//   trace_out    recorded output at rd_idx
//   trace_valid  rd_idx holds a recorded sample
// Modports: slave = step controller, master = FSM / board side.
interface fsm_step_ctrl_if import fsm_board_pkg::*; #(
    parameter int TRACE_DEPTH = 8
);

    localparam int IDX_W = $clog2(TRACE_DEPTH);

    logic                  step;
    logic [STEP_CNT_W-1:0] step_count;
    logic [STATE_W-1:0]    state_obs;
    logic                  out_obs;
    logic [IDX_W-1:0]      rd_idx;
    logic [STATE_W-1:0]    trace_state;
    logic                  trace_out;
    logic                  trace_valid;

    modport master (
        output state_obs, out_obs, rd_idx,
        input  step, step_count, trace_state, trace_out, trace_valid
    );

    modport slave (
        input  state_obs, out_obs, rd_idx,
        output step, step_count, trace_state, trace_out, trace_valid
    );

endinterface

// File: rtl/fsm_step_ctrl_debounce.sv
// btn_debounce
// Two-flop synchronizer followed by a four-state debounce FSM.
//   clk      system clock
//   reset    asynchronous, active-high
//   btn_raw  unsynchronized push button, high = pressed
//   btn_db   debounced button level
// Parameter DEBOUNCE_CYCLES: stable cycles required before btn_db changes.
module btn_debounce import fsm_board_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_db
);

    localparam int             CNT_W    = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q;
    logic             btn_s;
    db_state_t        state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next, cnt_inc;

    assign btn_s   = sync_q[1];
    assign cnt_inc = cnt + 1'b1;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= '0;
            state  <= IDLE_LOW;
            cnt    <= '0;
        end else begin
            sync_q <= {sync_q[0], btn_raw};
            state  <= state_next;
            cnt    <= cnt_next;
        end
    end

    // The idle-state cycle that first sees the new level is the first stable
    // cycle, so the wait state leaves once the incremented count reaches
    // DEBOUNCE_CYCLES-1: exactly DEBOUNCE_CYCLES stable cycles in total.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE_LOW: begin
                cnt_next = '0;
                if (btn_s) state_next = WAIT_HIGH;
            end
            WAIT_HIGH: begin
                if (!btn_s) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            IDLE_HIGH: begin
                cnt_next = '0;
                if (!btn_s) state_next = WAIT_LOW;
            end
            WAIT_LOW: begin
                if (btn_s) begin
                    state_next = IDLE_HIGH;
                    cnt_next   = '0;
                end else if (cnt_inc == CNT_LAST) begin
                    state_next = IDLE_LOW;
                    cnt_next   = '0;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            default: begin
                state_next = IDLE_LOW;
                cnt_next   = '0;
            end
        endcase
    end

    always_comb begin
        btn_db = (state == IDLE_HIGH) || (state == WAIT_LOW);
    end

endmodule

// File: rtl/fsm_step_ctrl.sv
// fsm_step_ctrl
// Step-pulse generator and trace recorder for the board-level Moore FSMs.
//   clk      system clock
//   reset    asynchronous, active-high
//   btn_raw  unsynchronized push button, high = pressed
//   auto_en  enables periodic stepping
//   bus      fsm_step_ctrl_if.slave: step, step_count, state_obs, out_obs,
//            rd_idx, trace_state, trace_out, trace_valid
// Optional feature macro STEP_TRACE_EN: when defined the trace buffer and
// readback are built; otherwise the trace outputs are tied to 0.
module fsm_step_ctrl import fsm_board_pkg::*; #(
    parameter int DEBOUNCE_CYCLES = 1_000_000,
    parameter int AUTO_PERIOD     = 50_000_000,
    parameter int TRACE_DEPTH     = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic btn_raw,
    input  logic auto_en,
    fsm_step_ctrl_if.slave bus
);

    localparam int               PER_W    = $clog2(AUTO_PERIOD);
    localparam logic [PER_W-1:0] PER_LAST = PER_W'(AUTO_PERIOD - 1);

    logic                  btn_db, btn_db_q;
    logic                  auto_en_q;
    logic [PER_W-1:0]      per_cnt;
    logic                  manual_req, auto_req;
    logic                  step_r;
    logic [STEP_CNT_W-1:0] count_r;

    btn_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .btn_db (btn_db)
    );

    // Press edge only; release is ignored. Manual and auto requests are
    // ORed so a coincident pair yields a single strobe.
    assign manual_req = btn_db & ~btn_db_q;
    assign auto_req   = auto_en_q & (per_cnt == PER_LAST);

    // auto_en is a board switch, so it is registered before it gates the
    // period counter; the first auto strobe lands AUTO_PERIOD+1 cycles
    // after the switch rises.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            btn_db_q  <= 1'b0;
            auto_en_q <= 1'b0;
            per_cnt   <= '0;
            step_r    <= 1'b0;
            count_r   <= '0;
        end else begin
            btn_db_q  <= btn_db;
            auto_en_q <= auto_en;
            if (!auto_en_q || auto_req) per_cnt <= '0;
            else                        per_cnt <= per_cnt + 1'b1;
            step_r <= manual_req | auto_req;
            if (step_r) count_r <= count_r + 1'b1;
        end
    end

    assign bus.step       = step_r;
    assign bus.step_count = count_r;

`ifdef STEP_TRACE_EN
    localparam int               IDX_W    = $clog2(TRACE_DEPTH);
    localparam logic [IDX_W:0]   FILL_MAX = (IDX_W + 1)'(TRACE_DEPTH);

    trace_entry_t     mem [TRACE_DEPTH];
    logic             step_d;
    logic [IDX_W-1:0] wr_ptr;
    logic [IDX_W:0]   fill;
    logic [IDX_W-1:0] rd_addr;
    trace_entry_t     rd_entry;
    logic             rd_valid;

    // The FSM moves on the edge where step is high, so its new state is
    // sampled one cycle later.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            step_d <= 1'b0;
            wr_ptr <= '0;
            fill   <= '0;
        end else begin
            step_d <= step_r;
            if (step_d) begin
                wr_ptr <= wr_ptr + 1'b1;
                if (fill != FILL_MAX) fill <= fill + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (step_d) mem[wr_ptr] <= '{state: bus.state_obs, out: bus.out_obs};
    end

    // Power-of-two depth: the subtraction wraps modulo TRACE_DEPTH for free.
    assign rd_addr  = wr_ptr - 1'b1 - bus.rd_idx;
    assign rd_entry = mem[rd_addr];
    assign rd_valid = ({1'b0, bus.rd_idx} < fill);

    assign bus.trace_state = rd_valid ? rd_entry.state : '0;
    assign bus.trace_out   = rd_valid & rd_entry.out;
    assign bus.trace_valid = rd_valid;
`else
    localparam int unused_trace_depth = TRACE_DEPTH;
    logic unused_obs;

    assign unused_obs      = ^{bus.state_obs, bus.out_obs, bus.rd_idx};
    assign bus.trace_state = '0;
    assign bus.trace_out   = 1'b0;
    assign bus.trace_valid = 1'b0;
`endif

endmodule

// File: tb/tb_fsm_step_ctrl.sv
// tb_fsm_step_ctrl
// Directed testbench for fsm_step_ctrl with DEBOUNCE_CYCLES=4, AUTO_PERIOD=5,
// TRACE_DEPTH=8. Trace expectations follow the STEP_TRACE_EN build setting.
// Inputs change 1 time unit after a rising edge; that interval is "cycle k".
module tb_fsm_step_ctrl;
    import fsm_board_pkg::*;

    logic clk;
    logic reset;
    logic btn_raw;
    logic auto_en;
    int   checks;
    int   errors;

    fsm_step_ctrl_if #(.TRACE_DEPTH(8)) bus ();

    fsm_step_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .AUTO_PERIOD    (5),
        .TRACE_DEPTH    (8)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_raw(btn_raw),
        .auto_en(auto_en),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        btn_raw       = 1'b0;
        auto_en       = 1'b0;
        bus.state_obs = '0;
        bus.out_obs   = 1'b0;
        bus.rd_idx    = '0;
        repeat (2) tick();
        reset = 1'b0;
    endtask

    // Wait (bounded) for a step strobe, then present the FSM's new state
    // in the following cycle, which is when the block samples it.
    task automatic do_step(input logic [2:0] v);
        int n;
        n = 0;
        while (bus.step !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        checks++;
        if (bus.step !== 1'b1) begin
            errors++;
            $display("[TB] FAIL step_timeout: step=%b after %0d cycles, expected 1", bus.step, n);
        end
        tick();
        bus.state_obs = v;
        bus.out_obs   = v[0];
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        btn_raw       = 1'b0;
        auto_en       = 1'b0;
        bus.state_obs = 3'd5;
        bus.out_obs   = 1'b1;
        bus.rd_idx    = '0;
        #3;
        checks++;
        if (bus.step !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_step: got %b expected 0", bus.step);
        end
        checks++;
        if (bus.step_count !== 8'd0) begin
            errors++; $display("[TB] FAIL reset_count: got %0d expected 0", bus.step_count);
        end
        checks++;
        if ({bus.trace_state, bus.trace_out, bus.trace_valid} !== 5'd0) begin
            errors++;
            $display("[TB] FAIL reset_trace: got state=%0d out=%b valid=%b expected all 0",
                     bus.trace_state, bus.trace_out, bus.trace_valid);
        end
        do_reset();
        repeat (3) tick();
        checks++;
        if ({bus.step, bus.step_count, bus.trace_valid} !== 10'd0) begin
            errors++;
            $display("[TB] FAIL idle_after_reset: got step=%b count=%0d valid=%b expected 0",
                     bus.step, bus.step_count, bus.trace_valid);
        end
    endtask

    task automatic test_debounce();
        int nsteps;
        int first;
        nsteps = 0;
        first  = -1;
        do_reset();
        for (int k = 0; k <= 50; k++) begin
            if (k < 12)      btn_raw = ((k % 4) < 2);
            else if (k < 32) btn_raw = 1'b1;
            else             btn_raw = 1'b0;
            if (bus.step === 1'b1) begin
                nsteps++;
                if (first < 0) first = k;
            end
            tick();
        end
        checks++;
        if (nsteps != 1) begin
            errors++; $display("[TB] FAIL debounce_pulses: got %0d expected 1", nsteps);
        end
        checks++;
        if (first != 19) begin
            errors++; $display("[TB] FAIL debounce_latency: step at cycle %0d expected 19", first);
        end
        checks++;
        if (bus.step_count !== 8'd1) begin
            errors++; $display("[TB] FAIL debounce_count: got %0d expected 1", bus.step_count);
        end
    endtask

    task automatic test_auto();
        logic [63:0] mask;
        logic [63:0] exp_mask;
        mask     = '0;
        exp_mask = (64'd1 << 6) | (64'd1 << 11) | (64'd1 << 16) | (64'd1 << 21);
        do_reset();
        for (int k = 0; k <= 35; k++) begin
            auto_en = (k <= 20);
            if (bus.step === 1'b1) mask[k] = 1'b1;
            tick();
        end
        checks++;
        if (mask !== exp_mask) begin
            errors++; $display("[TB] FAIL auto_cycles: got mask %h expected %h", mask, exp_mask);
        end
        checks++;
        if (bus.step_count !== 8'd4) begin
            errors++; $display("[TB] FAIL auto_count: got %0d expected 4", bus.step_count);
        end
    endtask

    task automatic test_coincident();
        logic [63:0] mask;
        mask = '0;
        do_reset();
        for (int k = 0; k <= 30; k++) begin
            btn_raw = (k <= 12);
            auto_en = (k >= 1) && (k <= 8);
            if (bus.step === 1'b1) mask[k] = 1'b1;
            tick();
        end
        checks++;
        if (mask !== (64'd1 << 7)) begin
            errors++; $display("[TB] FAIL coincident_cycles: got mask %h expected %h", mask, 64'd1 << 7);
        end
        checks++;
        if (bus.step_count !== 8'd1) begin
            errors++; $display("[TB] FAIL coincident_count: got %0d expected 1", bus.step_count);
        end
    endtask

    task automatic test_trace_short();
        logic [2:0] exp_state [4];
        logic       exp_out   [4];
        logic       exp_valid [4];
`ifdef STEP_TRACE_EN
        exp_state = '{3'd3, 3'd2, 3'd1, 3'd0};
        exp_out   = '{1'b1, 1'b0, 1'b1, 1'b0};
        exp_valid = '{1'b1, 1'b1, 1'b1, 1'b0};
`else
        exp_state = '{3'd0, 3'd0, 3'd0, 3'd0};
        exp_out   = '{1'b0, 1'b0, 1'b0, 1'b0};
        exp_valid = '{1'b0, 1'b0, 1'b0, 1'b0};
`endif
        do_reset();
        auto_en = 1'b1;
        do_step(3'd1);
        do_step(3'd2);
        do_step(3'd3);
        auto_en = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 4; i++) begin
            bus.rd_idx = 3'(i);
            #1;
            checks++;
            if (bus.trace_valid !== exp_valid[i]) begin
                errors++;
                $display("[TB] FAIL trace3_valid[%0d]: got %b expected %b", i, bus.trace_valid, exp_valid[i]);
            end
            checks++;
            if (bus.trace_state !== exp_state[i] || bus.trace_out !== exp_out[i]) begin
                errors++;
                $display("[TB] FAIL trace3_entry[%0d]: got state=%0d out=%b expected state=%0d out=%b",
                         i, bus.trace_state, bus.trace_out, exp_state[i], exp_out[i]);
            end
        end
    endtask

    task automatic test_trace_wrap();
        logic [2:0] es;
        logic       eo;
        logic       ev;
        do_reset();
        auto_en = 1'b1;
        for (int k = 0; k < 10; k++) do_step(3'(k % 8));
        auto_en = 1'b0;
        repeat (4) tick();
        for (int i = 0; i < 8; i++) begin
`ifdef STEP_TRACE_EN
            es = 3'((9 - i) % 8);
            eo = es[0];
            ev = 1'b1;
`else
            es = 3'd0;
            eo = 1'b0;
            ev = 1'b0;
`endif
            bus.rd_idx = 3'(i);
            #1;
            checks++;
            if (bus.trace_valid !== ev || bus.trace_state !== es || bus.trace_out !== eo) begin
                errors++;
                $display("[TB] FAIL trace10_entry[%0d]: got state=%0d out=%b valid=%b expected state=%0d out=%b valid=%b",
                         i, bus.trace_state, bus.trace_out, bus.trace_valid, es, eo, ev);
            end
        end
        bus.rd_idx = '0;
    endtask

    task automatic test_count_wrap();
        int nsteps;
        nsteps = 0;
        do_reset();
        auto_en = 1'b1;
        for (int k = 0; k <= 1283; k++) begin
            if (k == 1280) begin
                checks++;
                if (bus.step_count !== 8'd255) begin
                    errors++; $display("[TB] FAIL count_255: got %0d expected 255", bus.step_count);
                end
            end
            if (bus.step === 1'b1) nsteps++;
            tick();
        end
        auto_en = 1'b0;
        checks++;
        if (nsteps != 256) begin
            errors++; $display("[TB] FAIL wrap_pulses: got %0d expected 256", nsteps);
        end
        checks++;
        if (bus.step_count !== 8'd0) begin
            errors++; $display("[TB] FAIL count_wrap: got %0d expected 0", bus.step_count);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] mask;
        mask = '0;
        do_reset();
        auto_en = 1'b1;
        btn_raw = 1'b1;
        repeat (4) tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({bus.step, bus.step_count, bus.trace_state, bus.trace_out, bus.trace_valid} !== 14'd0) begin
            errors++;
            $display("[TB] FAIL midreset_outputs: got step=%b count=%0d state=%0d out=%b valid=%b expected all 0",
                     bus.step, bus.step_count, bus.trace_state, bus.trace_out, bus.trace_valid);
        end
        auto_en = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        for (int k = 0; k <= 15; k++) begin
            if (bus.step === 1'b1) mask[k] = 1'b1;
            tick();
        end
        btn_raw = 1'b0;
        checks++;
        if (mask !== (64'd1 << 7)) begin
            errors++; $display("[TB] FAIL midreset_restart: got mask %h expected %h", mask, 64'd1 << 7);
        end
        checks++;
        if (bus.step_count !== 8'd1) begin
            errors++; $display("[TB] FAIL midreset_count: got %0d expected 1", bus.step_count);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;
        $display("[TB] fsm_step_ctrl directed tests start");
        test_reset();
        test_debounce();
        test_auto();
        test_coincident();
        test_trace_short();
        test_trace_wrap();
        test_count_wrap();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
